cc_miss_request_unit: RTL and testbench
=======================================

# cc_miss_request_unit

Miss-issue stage of the cache controller, directly upstream of the data fill unit. Accepts one miss request at a time from the tag-compare/hit logic and pushes the full miss address into the miss address FIFO that the fill unit pops. Issues the matching 8-beat, 64-bit AXI read burst on the AR channel, and tracks outstanding line fills against a configurable limit.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: maximum line fills accepted but not yet completed (1..15).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- miss_req_i  input  1  miss request, held until acknowledged
- miss_addr_i  input  32  miss byte address, stable while miss_req_i=1
- miss_ack_o  output  1  one-cycle pulse: request accepted
- busy_o  output  1  1 when state is not IDLE
- miss_addr_fifo_full_i  input  1  miss address FIFO full
- miss_addr_fifo_wren_o  output  1  FIFO push strobe, one cycle per accepted miss
- miss_addr_fifo_wdata_o  output  32  address pushed
- mem_araddr_o  output  32  AXI AR address
- mem_arlen_o  output  4  burst length, constant 4'd7
- mem_arsize_o  output  3  beat size, constant 3'd3 (8 bytes)
- mem_arburst_o  output  2  burst type (see Configuration)
- mem_arvalid_o  output  1  AR valid
- mem_arready_i  input  1  AR ready
- fill_done_i  input  1  one-cycle pulse from fill unit when a line is written (its SRAM write enable)

## Operation
- States: IDLE, AR_REQ. Outstanding counter pend[3:0].
- IDLE: accept when miss_req_i & !miss_addr_fifo_full_i & (pend_next_base < MAX_OUTSTANDING). pend_next_base is pend after this cycle's fill_done_i decrement. On accept: capture address, go AR_REQ, pend += 1.
- AR_REQ: mem_arvalid_o=1 with mem_araddr_o stable. On mem_arvalid_o & mem_arready_i, go IDLE. The request is not re-accepted while in AR_REQ.
- FIFO push occurs in the same cycle as the first arvalid cycle. The fill unit therefore always has its FIFO entry before the first R beat can return.
- pend: +1 on accept, -1 on fill_done_i. Both in the same cycle leaves pend unchanged. fill_done_i with pend=0 is ignored, with no underflow.
- miss_ack_o, miss_addr_fifo_wren_o, mem_arvalid_o, busy_o and all data outputs are registered.
- Reset (any time, including mid-burst): state=IDLE, pend=0. All outputs 0 except constants (arlen=7, arsize=3, arburst per config). Any in-flight AR is abandoned, and the memory side is reset alongside.

## Timing
- Accept condition true at edge T:
  - at T+1: miss_ack_o=1, miss_addr_fifo_wren_o=1 (both for exactly 1 cycle), mem_arvalid_o=1, busy_o=1.
- arready high at T+1 edge → arvalid=0 and busy_o=0 at T+2. The earliest next accept is sampled at the T+2 edge.
- Peak throughput: one miss per 2 cycles.
- arvalid held indefinitely while arready=0, with no change to address.
- miss_addr_fifo_full_i is sampled only in IDLE. Fullness during AR_REQ has no effect because the push already happened.
- pend reaching MAX_OUTSTANDING blocks acceptance. A fill_done_i in the same cycle frees the slot immediately.

## Configuration
- Macro CC_CRITICAL_WORD_FIRST_EN.
- Defined:
  - mem_arburst_o=2'b10 (WRAP).
  - mem_araddr_o = {miss_addr_i[31:3],3'b000}.
  - FIFO wdata = {miss_addr_i[31:3],3'b000}.
  - The fill unit rotates beats by offset [5:3], so the requested word returns first.
- Undefined:
  - mem_arburst_o=2'b01 (INCR).
  - mem_araddr_o = {miss_addr_i[31:6],6'b0}.
  - FIFO wdata = {miss_addr_i[31:6],6'b0}, so offset 0.
  - Beats return in line order.

## Test plan
- Single miss, addr 0x1234_5678, arready=1 at first arvalid cycle:
  - ack, wren and arvalid all high one cycle later.
  - With macro: araddr=0x1234_5678, arburst=2'b10. Without: araddr=0x1234_5640, arburst=2'b01.
  - FIFO wdata equals araddr. arlen=7, arsize=3.
- arready held low 5 cycles: arvalid stays 1 and araddr stable for 6 cycles. wren pulses only once. busy_o drops the cycle after the handshake.
- MAX_OUTSTANDING=4, four back-to-back misses with arready=1 and no fill_done_i: accepts at 2-cycle spacing, fifth request held off. Pulse fill_done_i → fifth accepted that cycle, ack next cycle.
- miss_addr_fifo_full_i=1 with miss_req_i=1 for 10 cycles: no ack, no wren, no arvalid. Full drops → ack one cycle later.
- fill_done_i coincident with an accept at pend=2: pend stays 2. fill_done_i at pend=0: pend stays 0.
- rst_n asserted asynchronously while arvalid=1 in AR_REQ: outputs clear without waiting for a clock edge. After release, a new miss issues normally with pend starting from 0.

Source files
------------

// File: rtl/cc_miss_request_unit.sv
// -----------------------------------------------------------------------------
// cc_miss_request_unit
//
// Miss-issue stage of the cache controller. Takes one miss at a time from the
// tag-compare/hit logic. For each miss it pushes the line address into the
// miss address FIFO that the fill unit pops. It also issues the matching
// 8-beat x 64-bit AXI read burst on the AR channel, and it counts line fills
// that have been accepted but not yet completed.
//
// Optional feature macro: CC_CRITICAL_WORD_FIRST_EN
//   defined   : WRAP burst at the requested 8-byte word. The fill unit rotates
//               the beats using offset [5:3].
//   undefined : INCR burst from the 64-byte line base. Beats return in line
//               order.
//
// Parameters
//   MAX_OUTSTANDING        maximum line fills in flight (1..15)
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   miss_req_i/addr_i      miss request (held until ack) and byte address
//   miss_ack_o             one-cycle accept pulse
//   busy_o                 high while an AR is pending (state != IDLE)
//   miss_addr_fifo_*       full flag in; push strobe and data out
//   mem_ar*                AXI AR channel (len=7, size=3 are constants)
//   fill_done_i            one-cycle pulse from the fill unit per finished line
// -----------------------------------------------------------------------------
module cc_miss_request_unit #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_req_i,
  input  logic [31:0] miss_addr_i,
  output logic        miss_ack_o,
  output logic        busy_o,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic        fill_done_i
);

  localparam logic [3:0] MAX_C = MAX_OUTSTANDING[3:0];

`ifdef CC_CRITICAL_WORD_FIRST_EN
  localparam logic [1:0]  ARBURST_C = 2'b10;          // WRAP
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFF8;  // keep the 8-byte word
`else
  localparam logic [1:0]  ARBURST_C = 2'b01;          // INCR
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFC0;  // line base, offset 0
`endif

  // The FIFO entry and the AR address always carry the same value. The fill
  // unit derives the beat rotation from the address it pops.
  function automatic logic [31:0] issue_addr(input logic [31:0] a);
    return a & ADDR_MASK;
  endfunction

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    AR_REQ = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  pend_base;
  logic        accept;

  logic        ack_q;
  logic        busy_q;
  logic        wren_q;
  logic        arvalid_q;
  logic [31:0] wdata_q;
  logic [31:0] araddr_q;

  // The decrement is applied before the limit check. A fill_done_i in the
  // same cycle therefore frees its slot for an accept in that cycle.
  // A fill_done_i that arrives with nothing outstanding is dropped.
  always_comb begin
    pend_base = pend_q;
    if (fill_done_i && (pend_q != 4'd0)) begin
      pend_base = pend_q - 4'd1;
    end
    accept = (state_q == IDLE) && miss_req_i && !miss_addr_fifo_full_i &&
             (pend_base < MAX_C);
    pend_d = accept ? (pend_base + 4'd1) : pend_base;
  end

  // The FSM and all outputs are registered together in one block. The FIFO
  // push happens in the same cycle as the first arvalid. This guarantees the
  // fill unit has its entry before any R beat can return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 4'd0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      wren_q    <= 1'b0;
      arvalid_q <= 1'b0;
      wdata_q   <= 32'd0;
      araddr_q  <= 32'd0;
    end else begin
      pend_q <= pend_d;
      ack_q  <= 1'b0;
      wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= AR_REQ;
            ack_q     <= 1'b1;
            wren_q    <= 1'b1;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            wdata_q   <= issue_addr(miss_addr_i);
            araddr_q  <= issue_addr(miss_addr_i);
          end
        end
        AR_REQ: begin
          // The address is held until the handshake. FIFO fullness is
          // ignored here because the push has already happened.
          if (arvalid_q && mem_arready_i) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          arvalid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign miss_ack_o             = ack_q;
  assign busy_o                 = busy_q;
  assign miss_addr_fifo_wren_o  = wren_q;
  assign miss_addr_fifo_wdata_o = wdata_q;
  assign mem_araddr_o           = araddr_q;
  assign mem_arvalid_o          = arvalid_q;
  assign mem_arlen_o            = 4'd7;
  assign mem_arsize_o           = 3'd3;
  assign mem_arburst_o          = ARBURST_C;

endmodule

// File: tb/tb_cc_miss_request_unit.sv
// -----------------------------------------------------------------------------
// tb_cc_miss_request_unit
//
// Directed testbench for cc_miss_request_unit with MAX_OUTSTANDING = 4.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at the same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_cc_miss_request_unit;

  logic        clk;
  logic        rst_n;
  logic        miss_req_i;
  logic [31:0] miss_addr_i;
  logic        miss_ack_o;
  logic        busy_o;
  logic        miss_addr_fifo_full_i;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic        fill_done_i;

  int passed;
  int total;

`ifdef CC_CRITICAL_WORD_FIRST_EN
  localparam logic [31:0] EXP_A1    = 32'h1234_5678;
  localparam logic [31:0] EXP_A2    = 32'hABCD_0010;
  localparam logic [31:0] EXP_A3    = 32'h0000_00C8;
  localparam logic [1:0]  EXP_BURST = 2'b10;
`else
  localparam logic [31:0] EXP_A1    = 32'h1234_5640;
  localparam logic [31:0] EXP_A2    = 32'hABCD_0000;
  localparam logic [31:0] EXP_A3    = 32'h0000_00C0;
  localparam logic [1:0]  EXP_BURST = 2'b01;
`endif

  cc_miss_request_unit #(.MAX_OUTSTANDING(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .miss_req_i             (miss_req_i),
    .miss_addr_i            (miss_addr_i),
    .miss_ack_o             (miss_ack_o),
    .busy_o                 (busy_o),
    .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
    .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
    .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
    .mem_araddr_o           (mem_araddr_o),
    .mem_arlen_o            (mem_arlen_o),
    .mem_arsize_o           (mem_arsize_o),
    .mem_arburst_o          (mem_arburst_o),
    .mem_arvalid_o          (mem_arvalid_o),
    .mem_arready_i          (mem_arready_i),
    .fill_done_i            (fill_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    passed = 0;
    total  = 0;
    rst_n = 1'b0;
    miss_req_i = 1'b0;
    miss_addr_i = 32'd0;
    miss_addr_fifo_full_i = 1'b0;
    mem_arready_i = 1'b0;
    fill_done_i = 1'b0;
    tick();
    tick();

    // ---- reset state
    check("rst_ack",     {31'd0, miss_ack_o}, 32'd0);
    check("rst_busy",    {31'd0, busy_o}, 32'd0);
    check("rst_wren",    {31'd0, miss_addr_fifo_wren_o}, 32'd0);
    check("rst_arvalid", {31'd0, mem_arvalid_o}, 32'd0);
    check("rst_araddr",  mem_araddr_o, 32'd0);
    check("rst_wdata",   miss_addr_fifo_wdata_o, 32'd0);
    check("rst_arlen",   {28'd0, mem_arlen_o}, 32'd7);
    check("rst_arsize",  {29'd0, mem_arsize_o}, 32'd3);
    check("rst_arburst", {30'd0, mem_arburst_o}, {30'd0, EXP_BURST});
    rst_n = 1'b1;
    tick();

    // ---- single miss, arready high on the first arvalid cycle
    miss_req_i = 1'b1;
    miss_addr_i = 32'h1234_5678;
    mem_arready_i = 1'b1;
    tick();
    check("t1_ack",     {31'd0, miss_ack_o}, 32'd1);
    check("t1_wren",    {31'd0, miss_addr_fifo_wren_o}, 32'd1);
    check("t1_arvalid", {31'd0, mem_arvalid_o}, 32'd1);
    check("t1_busy",    {31'd0, busy_o}, 32'd1);
    check("t1_araddr",  mem_araddr_o, EXP_A1);
    check("t1_wdata",   miss_addr_fifo_wdata_o, EXP_A1);
    check("t1_arburst", {30'd0, mem_arburst_o}, {30'd0, EXP_BURST});
    check("t1_arlen",   {28'd0, mem_arlen_o}, 32'd7);
    check("t1_arsize",  {29'd0, mem_arsize_o}, 32'd3);
    miss_req_i = 1'b0;
    tick();
    check("t1_ack_off",     {31'd0, miss_ack_o}, 32'd0);
    check("t1_wren_off",    {31'd0, miss_addr_fifo_wren_o}, 32'd0);
    check("t1_arvalid_off", {31'd0, mem_arvalid_o}, 32'd0);
    check("t1_busy_off",    {31'd0, busy_o}, 32'd0);
    check("t1_pend",        {28'd0, dut.pend_q}, 32'd1);
    fill_done_i = 1'b1;
    tick();
    fill_done_i = 1'b0;
    check("t1_pend_drain", {28'd0, dut.pend_q}, 32'd0);

    // ---- arready held low: arvalid and address stay put, a single push
    mem_arready_i = 1'b0;
    miss_req_i = 1'b1;
    miss_addr_i = 32'hABCD_0017;
    tick();
    check("t2_wren_first", {31'd0, miss_addr_fifo_wren_o}, 32'd1);
    check("t2_araddr0",    mem_araddr_o, EXP_A2);
    miss_req_i = 1'b0;
    miss_addr_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_arvalid_%0d", i), {31'd0, mem_arvalid_o}, 32'd1);
      check($sformatf("t2_araddr_%0d", i), mem_araddr_o, EXP_A2);
      check($sformatf("t2_wren_%0d", i), {31'd0, miss_addr_fifo_wren_o}, 32'd0);
      check($sformatf("t2_busy_%0d", i), {31'd0, busy_o}, 32'd1);
    end
    mem_arready_i = 1'b1;
    tick();
    check("t2_arvalid_end", {31'd0, mem_arvalid_o}, 32'd0);
    check("t2_busy_end",    {31'd0, busy_o}, 32'd0);
    fill_done_i = 1'b1;
    tick();
    fill_done_i = 1'b0;
    check("t2_pend_drain", {28'd0, dut.pend_q}, 32'd0);

    // ---- four back-to-back misses reach the limit; fill_done frees a slot
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t3_ack_%0d", i), {31'd0, miss_ack_o}, 32'd1);
      tick();
      check($sformatf("t3_gap_%0d", i), {31'd0, miss_ack_o}, 32'd0);
    end
    check("t3_pend_full", {28'd0, dut.pend_q}, 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_held_ack_%0d", i), {31'd0, miss_ack_o}, 32'd0);
      check($sformatf("t3_held_arv_%0d", i), {31'd0, mem_arvalid_o}, 32'd0);
    end
    fill_done_i = 1'b1;
    tick();
    fill_done_i = 1'b0;
    miss_req_i = 1'b0;
    check("t3_fifth_ack", {31'd0, miss_ack_o}, 32'd1);
    check("t3_pend_after", {28'd0, dut.pend_q}, 32'd4);
    tick();
    check("t3_fifth_done", {31'd0, busy_o}, 32'd0);
    fill_done_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    fill_done_i = 1'b0;
    check("t3_pend_drain", {28'd0, dut.pend_q}, 32'd0);

    // ---- FIFO full blocks acceptance
    miss_addr_fifo_full_i = 1'b1;
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_2040;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t4_ack_%0d", i), {31'd0, miss_ack_o}, 32'd0);
      check($sformatf("t4_wren_%0d", i), {31'd0, miss_addr_fifo_wren_o}, 32'd0);
      check($sformatf("t4_arv_%0d", i), {31'd0, mem_arvalid_o}, 32'd0);
    end
    miss_addr_fifo_full_i = 1'b0;
    tick();
    miss_req_i = 1'b0;
    check("t4_ack_release", {31'd0, miss_ack_o}, 32'd1);
    tick();
    fill_done_i = 1'b1;
    tick();
    fill_done_i = 1'b0;
    check("t4_pend_drain", {28'd0, dut.pend_q}, 32'd0);

    // ---- fill_done coincident with accept at pend=2; fill_done at pend=0
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_3000;
    tick();
    tick();
    tick();
    miss_req_i = 1'b0;
    tick();
    check("t5_pend2", {28'd0, dut.pend_q}, 32'd2);
    miss_req_i = 1'b1;
    fill_done_i = 1'b1;
    tick();
    miss_req_i = 1'b0;
    fill_done_i = 1'b0;
    check("t5_coinc_ack",  {31'd0, miss_ack_o}, 32'd1);
    check("t5_coinc_pend", {28'd0, dut.pend_q}, 32'd2);
    tick();
    fill_done_i = 1'b1;
    tick();
    tick();
    check("t5_pend0", {28'd0, dut.pend_q}, 32'd0);
    tick();
    fill_done_i = 1'b0;
    check("t5_underflow", {28'd0, dut.pend_q}, 32'd0);

    // ---- asynchronous reset mid-burst, then a normal issue
    mem_arready_i = 1'b0;
    miss_req_i = 1'b1;
    miss_addr_i = 32'h5555_0008;
    tick();
    miss_req_i = 1'b0;
    check("t6_arv_before", {31'd0, mem_arvalid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arv_async",    {31'd0, mem_arvalid_o}, 32'd0);
    check("t6_busy_async",   {31'd0, busy_o}, 32'd0);
    check("t6_araddr_async", mem_araddr_o, 32'd0);
    check("t6_pend_async",   {28'd0, dut.pend_q}, 32'd0);
    rst_n = 1'b1;
    mem_arready_i = 1'b1;
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_00C8;
    tick();
    miss_req_i = 1'b0;
    check("t6_ack",    {31'd0, miss_ack_o}, 32'd1);
    check("t6_araddr", mem_araddr_o, EXP_A3);
    check("t6_wdata",  miss_addr_fifo_wdata_o, EXP_A3);
    check("t6_pend",   {28'd0, dut.pend_q}, 32'd1);
    tick();
    check("t6_done", {31'd0, busy_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
